// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall scheduler: forwarding selects,
// scheduler FSM states and the per-stage stall/flush strobe bundle.
package pipe_hazard_ctrl_pkg;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file value from ID/EX
        FWD_MEM = 2'b01,   // EX/MEM result
        FWD_WB  = 2'b10    // MEM/WB result
    } fwd_sel_t;

    // Data-memory wait tracking
    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_MEM_WAIT = 2'b01,
        HZ_ERR      = 2'b10
    } hz_state_t;

    // $0 is hard-wired to zero: never a real producer
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One bundle for every pipeline-register control strobe
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_wb;
    } hz_strobe_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding compare for one EX operand: the youngest in-flight producer
// (MEM) wins over the older one (WB); $0 is never forwarded.
module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_src,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output fwd_sel_t   sel
);

    // Priority compare: MEM result first, then WB result, else register file
    always_comb begin
        if (mem_regwrite && (mem_rd != REG_ZERO) && (mem_rd == ex_src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == ex_src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline. Combines data-memory wait
// stalls, EX redirects and load-use hazards into per-stage stall/flush
// strobes, selects EX operand forwarding, and counts stall/flush cycles.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_wb,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t       state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            mem_err_d;
    hz_strobe_t      strb;
    logic            mem_stall;
    logic            load_use;
    fwd_sel_t        fwd_a_sel, fwd_b_sel;

    pipe_fwd_sel u_fwd_a (
        .ex_src       (ex_rs),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a_sel)
    );

    pipe_fwd_sel u_fwd_b (
        .ex_src       (ex_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b_sel)
    );

    // State register: FSM state, wait-cycle counter and sticky error flag
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= HZ_RUN;
            wait_q  <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            mem_err <= mem_err_d;
        end
    end

    // Next-state logic: track consecutive dmem wait edges, give up after MEM_TIMEOUT
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value unassigned (no latch).
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err;
        case (state_q)
            HZ_RUN: begin
                if (mem_req && !dmem_ready) begin
                    state_d = HZ_MEM_WAIT;
                    wait_d  = TO_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = HZ_RUN;
                    wait_d  = '0;
                end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
                    state_d   = HZ_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HZ_ERR: begin
                state_d = HZ_ERR;
            end
            default: begin
                state_d = HZ_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Output logic: prioritised stall/flush strobes (mem-wait > redirect > load-use)
    always_comb begin
        mem_stall = !dmem_ready &&
                    (((state_q == HZ_RUN) && mem_req) || (state_q == HZ_MEM_WAIT));
        load_use  = ex_memread && ex_regwrite && (ex_rd != REG_ZERO) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        strb = '0;
        if (!rst_n) begin
            strb = '0;
        end else if (state_q == HZ_ERR) begin
            strb.stall_if  = 1'b1;
            strb.stall_id  = 1'b1;
            strb.stall_ex  = 1'b1;
            strb.stall_mem = 1'b1;
        end else if (mem_stall) begin
            strb.stall_if  = 1'b1;
            strb.stall_id  = 1'b1;
            strb.stall_ex  = 1'b1;
            strb.stall_mem = 1'b1;
            strb.flush_wb  = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is wrong-path, so a pending load-use is moot
            strb.flush_id = 1'b1;
            strb.flush_ex = 1'b1;
        end else if (load_use) begin
            strb.stall_if = 1'b1;
            strb.stall_id = 1'b1;
            strb.flush_ex = 1'b1;
        end
    end

    assign stall_if  = strb.stall_if;
    assign stall_id  = strb.stall_id;
    assign stall_ex  = strb.stall_ex;
    assign stall_mem = strb.stall_mem;
    assign flush_id  = strb.flush_id;
    assign flush_ex  = strb.flush_ex;
    assign flush_wb  = strb.flush_wb;
    assign fwd_a     = rst_n ? fwd_a_sel : FWD_RF;
    assign fwd_b     = rst_n ? fwd_b_sel : FWD_RF;

    // Saturating performance counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (strb.stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (strb.flush_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share the stimulus: index 0 uses
// the default parameters, index 1 uses MEM_TIMEOUT=4 and CNT_W=4 so timeout
// and counter saturation are reachable. A cycle-level model derived from the
// scheduling rules is compared on every falling edge, and directed sections
// pin the model with hand-computed literals.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_redirect;
    logic       mem_regwrite, mem_req, dmem_ready, wb_regwrite;

    logic [1:0] stall_if_v, stall_id_v, stall_ex_v, stall_mem_v;
    logic [1:0] flush_id_v, flush_ex_v, flush_wb_v, mem_err_v;
    logic [1:0] fwd_a_v [2];
    logic [1:0] fwd_b_v [2];
    logic [31:0] stall_cnt0, flush_cnt0;
    logic [3:0]  stall_cnt1, flush_cnt1;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .stall_if(stall_if_v[0]), .stall_id(stall_id_v[0]), .stall_ex(stall_ex_v[0]),
        .stall_mem(stall_mem_v[0]), .flush_id(flush_id_v[0]), .flush_ex(flush_ex_v[0]),
        .flush_wb(flush_wb_v[0]), .fwd_a(fwd_a_v[0]), .fwd_b(fwd_b_v[0]),
        .mem_err(mem_err_v[0]), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .stall_if(stall_if_v[1]), .stall_id(stall_id_v[1]), .stall_ex(stall_ex_v[1]),
        .stall_mem(stall_mem_v[1]), .flush_id(flush_id_v[1]), .flush_ex(flush_ex_v[1]),
        .flush_wb(flush_wb_v[1]), .fwd_a(fwd_a_v[1]), .fwd_b(fwd_b_v[1]),
        .mem_err(mem_err_v[1]), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // w = consecutive dmem wait edges seen so far (0 = not waiting)
    int     w    [2];
    bit     err  [2];
    longint scnt [2];
    longint fcnt [2];
    int     tmo  [2] = '{255, 4};
    longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}
    function automatic logic [6:0] exp_strobes(input int k);
        bit lu;
        if (!rst_n)                                 return 7'b0000000;
        if (err[k])                                 return 7'b1111000;
        if (!dmem_ready && (w[k] > 0 || mem_req))   return 7'b1111001;
        if (ex_redirect)                            return 7'b0000110;
        lu = ex_memread && ex_regwrite && ex_rd != 0 &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        if (lu)                                     return 7'b1100010;
        return 7'b0000000;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (!rst_n) return 2'd0;
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'd1;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src)    return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [6:0] s;
            s = exp_strobes(k);
            if (!rst_n) begin
                w[k] = 0; err[k] = 1'b0; scnt[k] = 0; fcnt[k] = 0;
            end else begin
                if (s[6] && scnt[k] < cmax[k]) scnt[k]++;
                if (s[2] && fcnt[k] < cmax[k]) fcnt[k]++;
                if (!err[k]) begin
                    if (w[k] > 0) begin
                        if (dmem_ready)      w[k] = 0;
                        else if (w[k] == tmo[k]) err[k] = 1'b1;
                        else                 w[k]++;
                    end else if (mem_req && !dmem_ready) begin
                        w[k] = 1;
                    end
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                logic [6:0] s, a;
                s = exp_strobes(k);
                a = {stall_if_v[k], stall_id_v[k], stall_ex_v[k], stall_mem_v[k],
                     flush_id_v[k], flush_ex_v[k], flush_wb_v[k]};
                check($sformatf("i%0d strobes", k), a, s);
                check($sformatf("i%0d fwd_a", k), fwd_a_v[k], exp_fwd(ex_rs));
                check($sformatf("i%0d fwd_b", k), fwd_b_v[k], exp_fwd(ex_rt));
                check($sformatf("i%0d mem_err", k), mem_err_v[k], err[k]);
                check($sformatf("i%0d stall_cnt", k), (k == 0) ? stall_cnt0 : stall_cnt1, scnt[k]);
                check($sformatf("i%0d flush_cnt", k), (k == 0) ? flush_cnt0 : flush_cnt1, fcnt[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_use_rs = 0; id_use_rt = 0; ex_regwrite = 0; ex_memread = 0; ex_redirect = 0;
        mem_regwrite = 0; mem_req = 0; dmem_ready = 0; wb_regwrite = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        settle();
        check("reset strobes zero", {stall_if_v, flush_ex_v, flush_wb_v}, 0);
        next();
        rst_n = 1'b1;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        next();
        armed = 1'b1;
        next();
        rst_n = 1'b1;

        // 1: load-use -> exactly one bubble
        do_reset();
        set_load_use();
        settle();
        check("t1 stall_if", stall_if_v, 2'b11);
        check("t1 flush_ex", flush_ex_v, 2'b11);
        check("t1 stall_ex", stall_ex_v, 2'b00);
        next();
        clear_inputs();
        settle();
        check("t1 stall_if clear", stall_if_v, 2'b00);
        check("t1 stall_cnt", stall_cnt0, 1);
        check("t1 stall_cnt_s", stall_cnt1, 1);

        // 2: $0 destination never stalls; forwarding priorities
        next();
        set_load_use();
        ex_rd = 0; id_rs = 0;
        ex_rs = 5'd5; mem_rd = 5'd5; mem_regwrite = 1; wb_rd = 5'd5; wb_regwrite = 1;
        settle();
        check("t2 no stall rd0", stall_if_v, 2'b00);
        check("t2 fwd_a mem", fwd_a_v[0], 2'b01);
        next();
        mem_regwrite = 0;
        settle();
        check("t2 fwd_a wb", fwd_a_v[0], 2'b10);
        next();
        ex_rt = 5'd7; wb_rd = 5'd7;
        settle();
        check("t2 fwd_b wb", fwd_b_v[0], 2'b10);
        check("t2 fwd_a rf", fwd_a_v[0], 2'b00);
        next();
        ex_rs = 0; mem_rd = 0; mem_regwrite = 1;
        settle();
        check("t2 fwd_a r0", fwd_a_v[1], 2'b00);
        next();
        clear_inputs();

        // 3: redirect overrides load-use
        do_reset();
        set_load_use();
        ex_redirect = 1;
        settle();
        check("t3 flush_id", flush_id_v, 2'b11);
        check("t3 flush_ex", flush_ex_v, 2'b11);
        check("t3 stall_if", stall_if_v, 2'b00);
        next();
        clear_inputs();
        settle();
        check("t3 flush_cnt", flush_cnt0, 1);

        // 4: three dmem wait cycles, redirect held and applied on release
        do_reset();
        mem_req = 1; dmem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t4 stall_mem", stall_mem_v, 2'b11);
            check("t4 flush_wb", flush_wb_v, 2'b11);
            check("t4 flush_id held", flush_id_v, 2'b00);
            next();
        end
        dmem_ready = 1;
        settle();
        check("t4 release stall", stall_if_v, 2'b00);
        check("t4 release flush_id", flush_id_v, 2'b11);
        next();
        clear_inputs();
        settle();
        check("t4 back to run", stall_if_v, 2'b00);
        check("t4 stall_cnt", stall_cnt0, 3);
        check("t4 flush_cnt", flush_cnt0, 1);

        // 5: timeout (small instance only), sticky until reset
        next();
        do_reset();
        mem_req = 1; dmem_ready = 0;
        repeat (4) next();
        settle();
        check("t5 no err after 4", mem_err_v, 2'b00);
        next();
        settle();
        check("t5 err after 5", mem_err_v, 2'b10);
        next();
        dmem_ready = 1;
        settle();
        check("t5 err sticky", mem_err_v, 2'b10);
        check("t5 err stalls", stall_if_v, 2'b10);
        check("t5 err no flush", flush_wb_v, 2'b00);
        next();
        next();
        settle();
        check("t5 err still", mem_err_v, 2'b10);
        next();
        clear_inputs();
        do_reset();
        settle();
        check("t5 err cleared", mem_err_v, 2'b00);

        // 6: reset mid-wait, then saturation of the 4-bit counter
        next();
        mem_req = 1; dmem_ready = 0;
        next();
        next();
        rst_n = 1'b0;
        settle();
        check("t6 reset forces zero", {stall_if_v, flush_wb_v}, 0);
        next();
        rst_n = 1'b1;
        mem_req = 0;
        settle();
        check("t6 state run", stall_if_v, 2'b00);
        check("t6 cnt zero", stall_cnt0, 0);
        next();
        mem_req = 1;
        repeat (20) next();
        clear_inputs();
        settle();
        check("t6 stall_cnt 20", stall_cnt0, 20);
        check("t6 stall_cnt sat", stall_cnt1, 15);
        next();
        dmem_ready = 1;
        next();
        do_reset();
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
